// File: rtl/pulse_channel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_channel_ctrl
//  Description : Control block for one pulse (square) sound channel. It holds
//                the channel registers and runs four pieces of state:
//                  - an 11-bit period timer, advanced at half the CPU rate,
//                    that produces sequencer step pulses
//                  - a length counter that gates the channel off when it
//                    expires
//                  - a decay envelope that is clocked by frame-sequencer
//                    quarter ticks
//                  - output volume gating, including the short-period mute
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   system clock
//    reset          in   1   synchronous active-high reset, overrides all
//    cpu_en         in   1   CPU-cycle enable; state advances only when high
//    reg_wr         in   1   register write strobe (qualified by cpu_en)
//    reg_addr       in   2   0=ctrl 1=sweep(ignored) 2=period lo 3=period hi/len
//    reg_wdata      in   8   register write data
//    channel_en     in   1   channel enable from the status register
//    quarter_frame  in   1   envelope tick (qualified by cpu_en)
//    half_frame     in   1   length tick (qualified by cpu_en)
//    duty           out  2   duty select for the duty sequencer
//    next_step      out  1   sequencer advance pulse, registered
//    seq_reset      out  1   sequencer reset pulse, registered
//    timer_period   out  11  current timer period
//    volume         out  4   gated channel volume
//    length_active  out  1   length counter nonzero, registered
// ============================================================================
module pulse_channel_ctrl #(
    parameter logic [10:0] MUTE_MIN = 11'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        reg_wr,
    input  logic [1:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        channel_en,
    input  logic        quarter_frame,
    input  logic        half_frame,
    output logic [1:0]  duty,
    output logic        next_step,
    output logic        seq_reset,
    output logic [10:0] timer_period,
    output logic [3:0]  volume,
    output logic        length_active
);

    // ------------------------------------------------------------------
    // Register map
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ADDR_CTRL  = 2'd0;
    localparam logic [1:0] c_ADDR_PLO   = 2'd2;
    localparam logic [1:0] c_ADDR_PHI   = 2'd3;
    localparam logic [3:0] c_DECAY_MAX  = 4'd15;

    // ------------------------------------------------------------------
    // Length table, indexed by the upper five bits of an addr3 write
    // ------------------------------------------------------------------
    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;
            5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;
            5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;
            5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;
            5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;
            5'd9:  val = 8'd8;
            5'd10: val = 8'd60;
            5'd11: val = 8'd10;
            5'd12: val = 8'd14;
            5'd13: val = 8'd12;
            5'd14: val = 8'd26;
            5'd15: val = 8'd14;
            5'd16: val = 8'd12;
            5'd17: val = 8'd16;
            5'd18: val = 8'd24;
            5'd19: val = 8'd18;
            5'd20: val = 8'd48;
            5'd21: val = 8'd20;
            5'd22: val = 8'd96;
            5'd23: val = 8'd22;
            5'd24: val = 8'd192;
            5'd25: val = 8'd24;
            5'd26: val = 8'd72;
            5'd27: val = 8'd26;
            5'd28: val = 8'd16;
            5'd29: val = 8'd28;
            5'd30: val = 8'd32;
            default: val = 8'd30;
        endcase
        return val;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  duty_q,       duty_d;
    logic        halt_q,       halt_d;        // length halt / envelope loop
    logic        const_vol_q,  const_vol_d;
    logic [3:0]  vol_q,        vol_d;         // volume or envelope divider period
    logic [10:0] period_q,     period_d;
    logic        phase_q,      phase_d;
    logic [10:0] count_q,      count_d;
    logic [7:0]  length_q,     length_d;
    logic        len_active_q, len_active_d;
    logic [3:0]  decay_q,      decay_d;
    logic [3:0]  divider_q,    divider_d;
    logic        env_start_q,  env_start_d;
    logic        next_step_q,  next_step_d;
    logic        seq_reset_q,  seq_reset_d;

    // ------------------------------------------------------------------
    // Qualified events
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_plo;
    logic w_wr_phi;
    logic w_apu_tick;
    logic w_qf;
    logic w_hf;

    assign w_wr       = reg_wr & cpu_en;
    assign w_wr_ctrl  = w_wr & (reg_addr == c_ADDR_CTRL);
    assign w_wr_plo   = w_wr & (reg_addr == c_ADDR_PLO);
    assign w_wr_phi   = w_wr & (reg_addr == c_ADDR_PHI);
    // The timer runs on every other CPU cycle, selected by the phase bit.
    assign w_apu_tick = cpu_en & phase_q;
    assign w_qf       = cpu_en & quarter_frame;
    assign w_hf       = cpu_en & half_frame;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        duty_d       = duty_q;
        halt_d       = halt_q;
        const_vol_d  = const_vol_q;
        vol_d        = vol_q;
        period_d     = period_q;
        phase_d      = phase_q;
        count_d      = count_q;
        length_d     = length_q;
        decay_d      = decay_q;
        divider_d    = divider_q;
        env_start_d  = env_start_q;
        // Pulses are recomputed every edge, so they drop whenever the
        // qualifying cpu_en cycle is absent.
        next_step_d  = 1'b0;
        seq_reset_d  = w_wr_phi;

        // Register writes
        if (w_wr_ctrl) begin
            duty_d      = reg_wdata[7:6];
            halt_d      = reg_wdata[5];
            const_vol_d = reg_wdata[4];
            vol_d       = reg_wdata[3:0];
        end
        if (w_wr_plo) begin
            period_d[7:0] = reg_wdata;
        end
        if (w_wr_phi) begin
            period_d[10:8] = reg_wdata[2:0];
        end

        // Phase and period timer. A period-high write deliberately leaves
        // the running count alone; the new period takes effect at the next
        // reload.
        if (cpu_en) begin
            phase_d = ~phase_q;
        end
        if (w_apu_tick) begin
            if (count_q == 11'd0) begin
                count_d     = period_q;
                next_step_d = 1'b1;
            end else begin
                count_d = count_q - 11'd1;
            end
        end

        // Length counter: disable dominates, then load, then decrement.
        if (!channel_en) begin
            length_d = 8'd0;
        end else if (w_wr_phi) begin
            length_d = len_lookup(reg_wdata[7:3]);
        end else if (w_hf && (length_q != 8'd0) && !halt_q) begin
            length_d = length_q - 8'd1;
        end

        // Envelope
        if (w_qf) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = c_DECAY_MAX;
                divider_d   = vol_q;
            end else if (divider_q == 4'd0) begin
                divider_d = vol_q;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (halt_q) begin
                    decay_d = c_DECAY_MAX;
                end
            end else begin
                divider_d = divider_q - 4'd1;
            end
        end
        // A restart requested in the same cycle as a quarter tick must
        // survive until the following tick, so the set wins over the clear.
        if (w_wr_phi) begin
            env_start_d = 1'b1;
        end

        len_active_d = (length_d != 8'd0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q       <= 2'd0;
            halt_q       <= 1'b0;
            const_vol_q  <= 1'b0;
            vol_q        <= 4'd0;
            period_q     <= 11'd0;
            phase_q      <= 1'b0;
            count_q      <= 11'd0;
            length_q     <= 8'd0;
            len_active_q <= 1'b0;
            decay_q      <= 4'd0;
            divider_q    <= 4'd0;
            env_start_q  <= 1'b0;
            next_step_q  <= 1'b0;
            seq_reset_q  <= 1'b0;
        end else begin
            duty_q       <= duty_d;
            halt_q       <= halt_d;
            const_vol_q  <= const_vol_d;
            vol_q        <= vol_d;
            period_q     <= period_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            length_q     <= length_d;
            len_active_q <= len_active_d;
            decay_q      <= decay_d;
            divider_q    <= divider_d;
            env_start_q  <= env_start_d;
            next_step_q  <= next_step_d;
            seq_reset_q  <= seq_reset_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        volume = 4'd0;
        if ((length_q != 8'd0) && (period_q >= MUTE_MIN)) begin
            volume = const_vol_q ? vol_q : decay_q;
        end
    end

    assign duty          = duty_q;
    assign next_step     = next_step_q;
    assign seq_reset     = seq_reset_q;
    assign timer_period  = period_q;
    assign length_active = len_active_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_channel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_channel_ctrl
//  Description : Self-checking bench for pulse_channel_ctrl. A behavioural
//                model of the channel is advanced on every rising edge and
//                compared against all DUT outputs on every falling edge;
//                directed sequences add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_channel_ctrl;

    localparam int MUTE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b1;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [7:0]  reg_wdata = 8'd0;
    logic        channel_en = 1'b0;
    logic        quarter_frame = 1'b0;
    logic        half_frame = 1'b0;
    logic [1:0]  duty;
    logic        next_step;
    logic        seq_reset;
    logic [10:0] timer_period;
    logic [3:0]  volume;
    logic        length_active;

    pulse_channel_ctrl #(.MUTE_MIN(11'd8)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_en        (cpu_en),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .channel_en    (channel_en),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .duty          (duty),
        .next_step     (next_step),
        .seq_reset     (seq_reset),
        .timer_period  (timer_period),
        .volume        (volume),
        .length_active (length_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int LEN [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                     12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

    int m_duty, m_halt, m_cv, m_vol, m_period, m_phase, m_count;
    int m_len, m_decay, m_div, m_start, m_ns, m_sr;
    bit m_wr;

    initial begin
        m_duty = 0; m_halt = 0; m_cv = 0; m_vol = 0; m_period = 0; m_phase = 0;
        m_count = 0; m_len = 0; m_decay = 0; m_div = 0; m_start = 0; m_ns = 0; m_sr = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_duty = 0; m_halt = 0; m_cv = 0; m_vol = 0; m_period = 0; m_phase = 0;
            m_count = 0; m_len = 0; m_decay = 0; m_div = 0; m_start = 0; m_ns = 0; m_sr = 0;
        end else begin
            m_ns = 0;
            m_sr = 0;
            m_wr = reg_wr && cpu_en;
            if (cpu_en) begin
                // APU-rate timer: one tick every second CPU cycle
                if (m_phase == 1) begin
                    if (m_count == 0) begin
                        m_count = m_period;
                        m_ns = 1;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
                m_phase = 1 - m_phase;
                // length
                if (channel_en && m_wr && reg_addr == 2'd3)
                    m_len = LEN[reg_wdata[7:3]];
                else if (half_frame && m_len > 0 && m_halt == 0)
                    m_len = m_len - 1;
                // envelope
                if (quarter_frame) begin
                    if (m_start == 1) begin
                        m_start = 0; m_decay = 15; m_div = m_vol;
                    end else if (m_div == 0) begin
                        m_div = m_vol;
                        if (m_decay > 0) m_decay = m_decay - 1;
                        else if (m_halt == 1) m_decay = 15;
                    end else begin
                        m_div = m_div - 1;
                    end
                end
                // register writes take effect after this edge's updates
                if (m_wr) begin
                    case (reg_addr)
                        2'd0: begin
                            m_duty = reg_wdata / 64;
                            m_halt = (reg_wdata / 32) % 2;
                            m_cv   = (reg_wdata / 16) % 2;
                            m_vol  = reg_wdata % 16;
                        end
                        2'd2: m_period = (m_period / 256) * 256 + reg_wdata;
                        2'd3: begin
                            m_period = (reg_wdata % 8) * 256 + (m_period % 256);
                            m_sr = 1;
                            m_start = 1;
                        end
                        default: ;
                    endcase
                end
            end
            if (!channel_en) m_len = 0;
        end
    end

    function automatic int model_volume();
        if (m_len == 0 || m_period < MUTE) return 0;
        return (m_cv == 1) ? m_vol : m_decay;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("duty",          int'(duty),          m_duty);
        check("next_step",     int'(next_step),     m_ns);
        check("seq_reset",     int'(seq_reset),     m_sr);
        check("timer_period",  int'(timer_period),  m_period);
        check("volume",        int'(volume),        model_volume());
        check("length_active", int'(length_active), (m_len != 0) ? 1 : 0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
    endtask

    // Edges until the next next_step pulse, bounded.
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (next_step !== 1'b1 && n < 200);
        if (next_step !== 1'b1) check("pulse_timeout", 0, 1);
    endtask

    int n;
    int exp_decay [7] = '{15,15,15,14,14,14,13};

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (3) tick();
        check("rst_duty", int'(duty), 0);
        check("rst_ns", int'(next_step), 0);
        check("rst_sr", int'(seq_reset), 0);
        check("rst_period", int'(timer_period), 0);
        check("rst_volume", int'(volume), 0);
        check("rst_len", int'(length_active), 0);
        reset = 1'b0;

        // ---------------- timer period 3 ----------------
        wr(2'd2, 8'd3);
        check("period3", int'(timer_period), 3);
        wait_pulse(n);
        wait_pulse(n);
        repeat (2) begin
            tick();
            check("ns_width", int'(next_step), 0);
            wait_pulse(n);
            check("ns_gap8", n + 1, 8);
        end

        // ---------------- length load / count / halt ----------------
        channel_en = 1'b1;
        wr(2'd3, 8'h08);
        check("len_load", int'(length_active), 1);
        half_frame = 1'b1;
        repeat (253) tick();
        check("len_253", int'(length_active), 1);
        tick();
        check("len_254", int'(length_active), 0);
        half_frame = 1'b0;
        wr(2'd0, 8'h20);
        wr(2'd3, 8'h08);
        half_frame = 1'b1;
        repeat (10) tick();
        half_frame = 1'b0;
        check("len_halt", int'(length_active), 1);

        // ---------------- disable ----------------
        wr(2'd3, 8'h10);
        check("len20", int'(length_active), 1);
        channel_en = 1'b0;
        tick();
        check("dis_clear", int'(length_active), 0);
        wr(2'd3, 8'h10);
        check("dis_block", int'(length_active), 0);
        channel_en = 1'b1;

        // ---------------- envelope ----------------
        wr(2'd0, 8'h02);
        wr(2'd2, 8'h40);
        wr(2'd3, 8'h08);
        check("env_period", int'(timer_period), 64);
        quarter_frame = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("env_seq", int'(volume), exp_decay[i]);
        end
        repeat (45) tick();
        check("env_zero", int'(volume), 0);
        repeat (6) tick();
        check("env_hold", int'(volume), 0);
        quarter_frame = 1'b0;
        wr(2'd0, 8'h22);
        quarter_frame = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (volume != 4'd15) tick();
        end
        check("env_wrap", int'(volume), 15);
        quarter_frame = 1'b0;

        // ---------------- mute and mid-count restart ----------------
        wr(2'd0, 8'h19);
        wr(2'd2, 8'd8);
        check("vol_p8", int'(volume), 9);
        check("duty_0", int'(duty), 0);
        wr(2'd2, 8'd7);
        check("vol_p7", int'(volume), 0);
        wait_pulse(n);
        wait_pulse(n);
        repeat (5) tick();
        wr(2'd3, 8'h08);
        check("sr_pulse", int'(seq_reset), 1);
        tick();
        check("sr_width", int'(seq_reset), 0);
        wait_pulse(n);
        check("no_reload_gap", 7 + n, 16);

        // ---------------- cpu_en gating ----------------
        wr(2'd0, 8'hC5);
        check("duty_3", int'(duty), 3);
        for (int i = 0; i < 48; i++) begin
            cpu_en        = (i % 3 != 2);
            quarter_frame = (i % 4 == 0);
            half_frame    = (i % 5 == 0);
            reg_wr        = (i == 10) || (i == 14);
            reg_addr      = (i == 10) ? 2'd3 : 2'd2;
            reg_wdata     = (i == 10) ? 8'h18 : 8'h30;
            tick();
        end
        cpu_en = 1'b1; quarter_frame = 1'b0; half_frame = 1'b0; reg_wr = 1'b0;
        check("gated_write", int'(timer_period), 7);

        // ---------------- reset with a step due ----------------
        wait_pulse(n);
        wait_pulse(n);
        repeat (15) tick();
        check("pre_reset_ns", int'(next_step), 0);
        reset = 1'b1;
        tick();
        check("mid_rst_ns", int'(next_step), 0);
        check("mid_rst_sr", int'(seq_reset), 0);
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_period", int'(timer_period), 0);
        check("mid_rst_volume", int'(volume), 0);
        check("mid_rst_len", int'(length_active), 0);
        reset = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
